// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg : shared playfield geometry and projectile FSM state encoding
// Rev 1.0
// ============================================================================
package game_pkg;

  localparam logic [9:0] SENTINEL_COORD   = 10'h3FF;
  localparam int         GRID_WIDTH       = 40;
  localparam int         PROJECTILE_WIDTH = 14;
  localparam int         LEFT_BOUND       = 0;
  localparam int         RIGHT_BOUND      = 640;
  localparam int         TOP_BOUND        = 35;
  localparam int         ALIENS_WIN_LINE  = 410;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    HOLD   = 2'd2
  } proj_state_e;

endpackage
`default_nettype wire

// File: rtl/alien_hit_detector.sv
`default_nettype none
// ============================================================================
// alien_hit_detector : one-hot of the lowest-index live alien overlapping
//                      the projectile box (3x2 grid, pitch 2*GRID_W)
// Rev 1.0
// ============================================================================
module alien_hit_detector
  import game_pkg::*;
#(
  parameter int GRID_W = GRID_WIDTH,
  parameter int PROJ_W = PROJECTILE_WIDTH
) (
  input  logic [9:0] proj_x_i,
  input  logic [9:0] proj_y_i,
  input  logic [9:0] aliens_x_i,
  input  logic [9:0] aliens_y_i,
  input  logic [5:0] alive_i,
  output logic [5:0] hit_o
);

  logic [10:0] px_ext;
  logic [10:0] py_ext;
  logic [5:0]  match;

  assign px_ext = {1'b0, proj_x_i};
  assign py_ext = {1'b0, proj_y_i};

  for (genvar k = 0; k < 6; k++) begin : g_alien
    localparam logic [10:0] X_OFF = 11'(2 * (k % 3) * GRID_W);
    localparam logic [10:0] Y_OFF = 11'(2 * (k / 3) * GRID_W);
    logic [10:0] ax;
    logic [10:0] ay;
    assign ax = {1'b0, aliens_x_i} + X_OFF;
    assign ay = {1'b0, aliens_y_i} + Y_OFF;
    // px > ax - PROJ_W rewritten as px + PROJ_W > ax so nothing can underflow
    assign match[k] = alive_i[k]
                    & (py_ext > ay) & (py_ext < ay + 11'(GRID_W))
                    & (px_ext + 11'(PROJ_W) > ax) & (px_ext < ax + 11'(GRID_W));
  end

  always_comb begin
    hit_o = '0;
    for (int k = 5; k >= 0; k--) begin
      if (match[k]) hit_o = 6'b1 << k;
    end
  end

endmodule
`default_nettype wire

// File: rtl/projectile_controller.sv
`default_nettype none
// ============================================================================
// projectile_controller : fire-button launch, tick-stepped flight, alien hit
//                         detection with a hold window before retirement
// Rev 1.0
// ============================================================================
module projectile_controller
  import game_pkg::*;
#(
  parameter int SHIP_Y     = 450,
  parameter int SHIP_W     = 40,
  parameter int PROJ_W     = PROJECTILE_WIDTH,
  parameter int PROJ_H     = 20,
  parameter int STEP       = 8,
  parameter int TOP_LIMIT  = TOP_BOUND,
  parameter int MOVE_TICKS = 416666,
  parameter int HIT_HOLD   = 4
) (
  input  logic       clk_master,
  input  logic       d_reset_n,
  input  logic       fire_btn,
  input  logic [9:0] ship_x,
  input  logic [9:0] aliens_x,
  input  logic [9:0] aliens_y,
  input  logic [5:0] index_aliens,
  input  logic       game_over,
  output logic [9:0] projectile_x,
  output logic [9:0] projectile_y,
  output logic [5:0] hit_alien,
  output logic       miss_pulse,
  output logic       busy
);

  localparam int TICK_W = $clog2(MOVE_TICKS + 1);
  localparam int HOLD_W = $clog2(HIT_HOLD + 1);

  proj_state_e       state_q;
  logic [9:0]        px_q;
  logic [9:0]        py_q;
  logic [5:0]        hit_q;
  logic              miss_q;
  logic              busy_q;
  logic [TICK_W-1:0] tick_q;
  logic [HOLD_W-1:0] hold_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              fire_prev_q;

  logic              fire_edge;
  logic              tick_done;
  logic [5:0]        hit_vec;

  assign fire_edge = sync2_q & ~fire_prev_q;
  assign tick_done = (tick_q == TICK_W'(MOVE_TICKS - 1));

  alien_hit_detector #(
    .GRID_W (GRID_WIDTH),
    .PROJ_W (PROJ_W)
  ) u_hit (
    .proj_x_i   (px_q),
    .proj_y_i   (py_q),
    .aliens_x_i (aliens_x),
    .aliens_y_i (aliens_y),
    .alive_i    (index_aliens),
    .hit_o      (hit_vec)
  );

  always_ff @(posedge clk_master or negedge d_reset_n) begin
    if (!d_reset_n) begin
      state_q     <= IDLE;
      px_q        <= SENTINEL_COORD;
      py_q        <= SENTINEL_COORD;
      hit_q       <= '0;
      miss_q      <= 1'b0;
      busy_q      <= 1'b0;
      tick_q      <= '0;
      hold_q      <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      fire_prev_q <= 1'b0;
    end else begin
      sync1_q     <= fire_btn;
      sync2_q     <= sync1_q;
      fire_prev_q <= sync2_q;
      hit_q       <= '0;
      miss_q      <= 1'b0;

      case (state_q)
        IDLE: begin
          if (fire_edge && !game_over) begin
            state_q <= FLIGHT;
            busy_q  <= 1'b1;
            px_q    <= ship_x + 10'(SHIP_W / 2 - PROJ_W / 2);
            py_q    <= 10'(SHIP_Y - PROJ_H);
            tick_q  <= '0;
          end
        end

        FLIGHT: begin
          if (game_over) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            px_q    <= SENTINEL_COORD;
            py_q    <= SENTINEL_COORD;
          end else if (|hit_vec) begin
            // a hit beats a same-cycle move so the alien sees the hit coordinates
            hit_q   <= hit_vec;
            state_q <= HOLD;
            hold_q  <= '0;
          end else if (tick_done) begin
            tick_q <= '0;
            if (py_q < 10'(TOP_LIMIT + STEP)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              miss_q  <= 1'b1;
              px_q    <= SENTINEL_COORD;
              py_q    <= SENTINEL_COORD;
            end else begin
              py_q <= py_q - 10'(STEP);
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end

        HOLD: begin
          if (game_over || hold_q == HOLD_W'(HIT_HOLD - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            px_q    <= SENTINEL_COORD;
            py_q    <= SENTINEL_COORD;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          px_q    <= SENTINEL_COORD;
          py_q    <= SENTINEL_COORD;
        end
      endcase
    end
  end

  assign projectile_x = px_q;
  assign projectile_y = py_q;
  assign hit_alien    = hit_q;
  assign miss_pulse   = miss_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_projectile_controller.sv
`default_nettype none
// ============================================================================
// tb_projectile_controller : directed scenarios plus randomized traffic,
//                            every cycle compared against a behavioural model
// Rev 1.0
// ============================================================================
module tb_projectile_controller;

  localparam int MT = 4;
  localparam int HH = 4;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       fire      = 1'b0;
  logic [9:0] ship_x    = 10'd300;
  logic [9:0] aliens_x  = 10'd304;
  logic [9:0] aliens_y  = 10'd134;
  logic [5:0] alive     = 6'd0;
  logic       game_over = 1'b0;
  logic [9:0] px;
  logic [9:0] py;
  logic [5:0] hit;
  logic       miss;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  projectile_controller #(
    .MOVE_TICKS (MT),
    .HIT_HOLD   (HH)
  ) dut (
    .clk_master   (clk),
    .d_reset_n    (rst_n),
    .fire_btn     (fire),
    .ship_x       (ship_x),
    .aliens_x     (aliens_x),
    .aliens_y     (aliens_y),
    .index_aliens (alive),
    .game_over    (game_over),
    .projectile_x (px),
    .projectile_y (py),
    .hit_alien    (hit),
    .miss_pulse   (miss),
    .busy         (busy)
  );

  // ---------------- behavioural model ----------------
  int m_px = 1023, m_py = 1023, m_hit = 0, m_flight_cycles = 0, m_held = 0;
  bit m_miss = 0, m_active = 0, m_holding = 0;
  bit pin_hist [3];   // fire pin as seen at the last three clock edges

  function automatic int first_hit(int x, int y, int ax0, int ay0, logic [5:0] live);
    for (int k = 0; k < 6; k++) begin
      int ax, ay;
      ax = ax0 + 80 * (k % 3);
      ay = ay0 + 80 * (k / 3);
      if (live[k] && y > ay && y < ay + 40 && x > ax - 14 && x < ax + 40) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_px = 1023; m_py = 1023; m_hit = 0; m_miss = 0;
    m_active = 0; m_holding = 0; m_flight_cycles = 0; m_held = 0;
    for (int i = 0; i < 3; i++) pin_hist[i] = 0;
  endtask

  task automatic model_retire();
    m_active = 0; m_holding = 0; m_px = 1023; m_py = 1023;
  endtask

  task automatic model_step();
    bit launch_req;
    int k;
    launch_req = pin_hist[1] && !pin_hist[2];
    pin_hist[2] = pin_hist[1];
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = fire;
    m_hit = 0;
    m_miss = 0;
    if (!m_active) begin
      if (launch_req && !game_over) begin
        m_active = 1; m_holding = 0; m_flight_cycles = 0;
        m_px = int'(ship_x) + 20 - 7;
        m_py = 450 - 20;
      end
    end else if (game_over) begin
      model_retire();
    end else if (m_holding) begin
      m_held++;
      if (m_held == HH) model_retire();
    end else begin
      k = first_hit(m_px, m_py, int'(aliens_x), int'(aliens_y), alive);
      if (k >= 0) begin
        m_hit = 1 << k; m_holding = 1; m_held = 0;
      end else begin
        m_flight_cycles++;
        if (m_flight_cycles % MT == 0) begin
          if (m_py < 35 + 8) begin
            model_retire(); m_miss = 1;
          end else begin
            m_py = m_py - 8;
          end
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [26:0] exp_v;
    exp_v = {m_px[9:0], m_py[9:0], m_hit[5:0], m_miss};
    checks++;
    if ({px, py, hit, miss} !== exp_v || busy !== m_active) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: got x=%0d y=%0d hit=%b miss=%b busy=%b, expected x=%0d y=%0d hit=%b miss=%b busy=%b",
               $time, px, py, hit, miss, busy, m_px, m_py, m_hit[5:0], m_miss, m_active);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare_outputs();
      if (rst_n) model_step();
    end
  end

  // ---------------- helpers ----------------
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fire_pulse();
    tick(); fire = 1'b1;
    repeat (2) tick();
    fire = 1'b0;
  endtask

  task automatic wait_hit(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (hit != 6'd0) return;
    end
    checks++; errors++;
    $display("FAIL %s: no hit within %0d cycles, expected a hit", name, max_cycles);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int last_y;
    bit got;

    // reset, with a fire pulse that starts and ends inside reset
    repeat (2) tick();
    fire = 1'b1;
    repeat (2) tick();
    fire = 1'b0;
    @(negedge clk);
    lit("reset_x", int'(px), 1023);
    lit("reset_y", int'(py), 1023);
    lit("reset_busy", int'(busy), 0);
    tick(); rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    lit("no_launch_after_reset", int'(busy), 0);

    // launch + hit on alien 0
    ship_x = 10'd300; aliens_x = 10'd304; aliens_y = 10'd134; alive = 6'b110111;
    tick(); fire = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit("launch_latency_busy", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    lit("launch_x", int'(px), 313);
    lit("launch_y", int'(py), 430);
    lit("launch_busy", int'(busy), 1);
    tick(); fire = 1'b0;
    repeat (4) tick();
    fire = 1'b1;               // second press mid-flight is dropped
    repeat (3) tick();
    fire = 1'b0;
    wait_hit(400, "hit_timeout");
    lit("hit_onehot", int'(hit), 1);
    lit("hit_x", int'(px), 313);
    lit("hit_y", int'(py), 166);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("hold_y", int'(py), 166);
      lit("hold_pulse_gone", int'(hit), 0);
    end
    @(negedge clk);
    lit("hold_retire_y", int'(py), 1023);
    lit("hold_retire_busy", int'(busy), 0);

    // miss off the top
    tick(); alive = 6'd0;
    fire_pulse();
    last_y = 1023; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (miss) got = 1; else last_y = int'(py);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL miss_timeout: no miss_pulse within 400 cycles, expected one");
    end
    lit("miss_last_y", last_y, 38);
    lit("miss_retire_y", int'(py), 1023);
    lit("miss_busy", int'(busy), 0);

    // priority: row 1 reached first
    tick(); aliens_x = 10'd306; aliens_y = 10'd134; alive = 6'b111111;
    fire_pulse();
    wait_hit(400, "prio_timeout");
    lit("prio_onehot", int'(hit), 8);
    lit("prio_y", int'(py), 246);
    repeat (8) tick();

    // game_over mid-flight, then fire blocked
    alive = 6'd0;
    fire_pulse();
    repeat (15) tick();
    @(negedge clk);
    lit("go_busy_before", int'(busy), 1);
    tick(); game_over = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lit("go_retire_y", int'(py), 1023);
    lit("go_busy", int'(busy), 0);
    lit("go_no_miss", int'(miss), 0);
    fire_pulse();
    repeat (6) tick();
    @(negedge clk);
    lit("go_fire_blocked", int'(busy), 0);
    tick(); game_over = 1'b0;
    repeat (4) tick();

    // asynchronous reset mid-flight
    fire_pulse();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    lit("async_reset_x", int'(px), 1023);
    lit("async_reset_busy", int'(busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sx;
      tick();
      if ($urandom_range(0, 7) == 0) fire = ~fire;
      if ($urandom_range(0, 59) == 0) begin
        sx       = int'($urandom_range(130, 800));
        ship_x   = 10'(sx);
        aliens_x = 10'(sx - 130 + int'($urandom_range(0, 170)));
        aliens_y = 10'($urandom_range(40, 330));
        alive    = 6'($urandom);
      end
      if ($urandom_range(0, 249) == 0) game_over = 1'b1;
      else if (game_over && $urandom_range(0, 9) == 0) game_over = 1'b0;
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
